// File: rtl/register_transfer_sequencer_if.sv
// Command handshake and register-file control signals shared between the
// decode side (master) and the transfer sequencer (slave).
interface register_transfer_sequencer_if #(
  parameter int LVL_W = 3
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_src;
  logic [2:0]       cmd_dst;
  logic [11:0]      Register_Control_Bus;
  logic             ext_drive;
  logic             done;
  logic             err;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
  logic [15:0]      xfer_count;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    input  cmd_ready, Register_Control_Bus, ext_drive, done, err, busy,
           fifo_level, xfer_count
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    output cmd_ready, Register_Control_Bus, ext_drive, done, err, busy,
           fifo_level, xfer_count
  );
endinterface

// File: rtl/register_transfer_sequencer.sv
// Queues register-to-register transfer commands and sequences the register
// file control bus: validate, settle (output enable only), then latch
// (output enable plus write enable), followed by a done/err pulse.
module register_transfer_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  register_transfer_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SETUP,
    S_XFER
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [2:0]       r_fifo_src [FIFO_DEPTH];
  logic [2:0]       r_fifo_dst [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_next;

  logic [2:0]       r_cmd_src;
  logic [2:0]       r_cmd_dst;

  logic [11:0]      r_bus;
  logic             r_ext;
  logic             r_done;
  logic             r_err;
  logic             r_busy;
  logic [15:0]      r_xfer_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_illegal;
  logic             w_is_ext;
  logic [5:0]       w_oe;
  logic [5:0]       w_we;
  logic [11:0]      w_bus_next;
  logic             w_ext_next;
  logic             w_done_next;
  logic             w_err_next;

  // Register code (A..ST) to a one-hot enable; EXT and invalid codes map to 0.
  function automatic logic [5:0] onehot6(input logic [2:0] code);
    logic [5:0] m;
    m = 6'd0;
    case (code)
      3'd0: m = 6'b000001;
      3'd1: m = 6'b000010;
      3'd2: m = 6'b000100;
      3'd3: m = 6'b001000;
      3'd4: m = 6'b010000;
      3'd5: m = 6'b100000;
      default: m = 6'd0;
    endcase
    return m;
  endfunction

  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty      = (r_level == '0);
  // Ready looks only at occupancy, so a same-cycle pop never frees a full FIFO.
  assign w_push       = bus.cmd_valid && !w_full;
  assign w_pop        = (r_state == S_IDLE) && !w_empty;
  assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign w_is_ext  = (r_cmd_src == 3'd7);
  assign w_illegal = (r_cmd_src == 3'd6) || (r_cmd_dst > 3'd5) ||
                     (r_cmd_src == r_cmd_dst);
  assign w_oe      = onehot6(r_cmd_src);
  assign w_we      = onehot6(r_cmd_dst);

  // Command storage; written on push only, never needs a reset value.
  always_ff @(posedge clock_in) begin
    if (w_push) begin
      r_fifo_src[r_wr_ptr] <= bus.cmd_src;
      r_fifo_dst[r_wr_ptr] <= bus.cmd_dst;
    end
  end

  // Head of the FIFO is captured into the working command register on pop.
  always_ff @(posedge clock_in) begin
    if (w_pop) begin
      r_cmd_src <= r_fifo_src[r_rd_ptr];
      r_cmd_dst <= r_fifo_dst[r_rd_ptr];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_next;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and the control values to present during the next cycle.
  always_comb begin
    w_next_state = r_state;
    w_bus_next   = 12'd0;
    w_ext_next   = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_next_state = S_CHECK;
      end
      S_CHECK: begin
        if (w_illegal) begin
          w_err_next   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SETUP;
          w_bus_next   = {w_oe, 6'd0};
          w_ext_next   = w_is_ext;
        end
      end
      S_SETUP: begin
        w_next_state = S_XFER;
        w_bus_next   = {w_oe, w_we};
        w_ext_next   = w_is_ext;
      end
      S_XFER: begin
        w_next_state = S_IDLE;
        w_done_next  = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs; the async reset drops every enable at once.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_bus        <= 12'd0;
      r_ext        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_xfer_count <= 16'd0;
    end else begin
      r_bus  <= w_bus_next;
      r_ext  <= w_ext_next;
      r_done <= w_done_next;
      r_err  <= w_err_next;
      r_busy <= (w_level_next != '0) || (w_next_state != S_IDLE);
      if (r_state == S_XFER) r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign bus.cmd_ready            = !w_full;
  assign bus.Register_Control_Bus = r_bus;
  assign bus.ext_drive            = r_ext;
  assign bus.done                 = r_done;
  assign bus.err                  = r_err;
  assign bus.busy                 = r_busy;
  assign bus.fifo_level           = r_level;
  assign bus.xfer_count           = r_xfer_count;

endmodule

// File: doc/register_transfer_sequencer.md
Name: register_transfer_sequencer

Overview:
- Issues queued register-to-register transfer commands onto the 12-bit Register_Control_Bus consumed by the register file (A, B, C, P, S, ST).
- Field layout of that bus: bits [5:0] are per-register write enables and bits [11:6] are per-register output enables, in the order A, B, C, P, S, ST.
- Sits upstream of the register file, between microcode/decode and the shared 16-bit data bus.
- Guarantees one-hot enables, a settle cycle before every latch, and a completion/error handshake.

Parameters:
- FIFO_DEPTH, 4: number of command entries; power of two, minimum 2.
- LVL_W, 3: width of fifo_level; must equal log2(FIFO_DEPTH)+1.

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_src  input  3  source code: 0=A, 1=B, 2=C, 3=P, 4=S, 5=ST, 7=EXT (bus driven externally), 6=invalid.
- cmd_dst  input  3  destination code: 0..5 valid; 6 and 7 invalid.
- Register_Control_Bus  output  12  bits [5:0] write enables and bits [11:6] output enables, A..ST; registered.
- ext_drive  output  1  external agent must drive the bus; asserted during SETUP and XFER of EXT-source commands.
- done  output  1  one-cycle pulse after each completed transfer.
- err  output  1  one-cycle pulse when an illegal command is discarded.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- fifo_level  output  LVL_W  current FIFO occupancy.
- xfer_count  output  16  count of completed transfers; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (reset_n low, asynchronous): Register_Control_Bus=0, ext_drive=0, done=0, err=0, busy=0, fifo_level=0, xfer_count=0, FIFO emptied, FSM=IDLE. cmd_ready=1 once reset is released.
- Reset asserted mid-transfer: all enables drop immediately, without waiting for a clock edge. The in-flight command is lost and produces no done.
- FIFO push: occurs when cmd_valid && cmd_ready.
- cmd_ready = !full. It depends only on occupancy, so a push is refused when the FIFO is full even if a pop happens in the same cycle.
- Simultaneous push and pop when neither full nor empty: fifo_level is unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, CHECK, SETUP, XFER.
- IDLE: if the FIFO is non-empty, pop the head into a command register and go to CHECK. Otherwise stay in IDLE.
- CHECK: the command is illegal if src==6, dst>5, or src==dst.
  - Illegal: err=1 for one cycle; no enables driven; xfer_count unchanged; next state IDLE.
  - Legal: next state SETUP.
- SETUP (1 cycle): assert the source output-enable bit only (bit 6+src), or ext_drive for EXT. All write enables stay 0. This allows the register file's output register to load and the bus to settle.
- XFER (1 cycle): keep the same output enable (or ext_drive) and add the write-enable bit for dst. The register file latches on the falling edge inside this cycle.
- Leaving XFER: the next cycle has Register_Control_Bus=0, ext_drive=0, done=1, and xfer_count+1. The FSM returns to IDLE.
- Enable guarantees: at most one output-enable bit and at most one write-enable bit are set in any cycle. Output enables are never asserted for an EXT source.
- Latency, legal command pushed into an empty idle block at cycle T: pop at T+1, CHECK at T+2, SETUP at T+3, XFER at T+4, done at T+5.
- Throughput: 4 cycles per legal transfer, 2 cycles per illegal command.
- busy is registered. It is high whenever the FIFO is non-empty or the state is not IDLE, and it falls in the cycle done or err is reported for the last command.

Test Plan:
- After reset, push (src=0 A, dst=1 B) -> Register_Control_Bus is 0x040 in SETUP, then 0x042 in XFER, then 0x000 with done=1; xfer_count=1.
- Push (src=7 EXT, dst=3 P) -> ext_drive=1 for 2 cycles; Register_Control_Bus is 0x000 in SETUP, 0x008 in XFER; done=1 afterwards.
- Push (2,2), then (6,0), then (0,7) -> three err pulses, no nonzero Register_Control_Bus, xfer_count unchanged; busy drops after the third err.
- Push 5 commands back-to-back with FIFO_DEPTH=4 -> cmd_ready low once 4 are held; the 5th is accepted after the first pop; all 5 complete in order with 5 done pulses.
- Assert reset_n low during XFER of (4 S, 5 ST) -> Register_Control_Bus reads 0 before the next clock edge; no done; fifo_level=0 and xfer_count=0 after reset.
- Preload xfer_count to 0xFFFF via 65535 transfers (or force), then one transfer -> xfer_count=0x0000.
